// File: rtl/uart_hex_framer.sv
// Buffers 16-bit energy samples in a small FIFO and sends each one to a byte UART
// as four uppercase ASCII hex digits followed by CR LF.
module uart_hex_framer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_n_i,
    input  logic [15:0]                   smp_dat_i,
    input  logic                          smp_vld_i,
    output logic                          smp_rdy_o,
    input  logic                          uart_busy_i,
    output logic                          uart_wr_o,
    output logic [7:0]                    uart_dat_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic                          ovf_o,
    input  logic                          ovf_clr_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WR,
        ACK,
        DRAIN
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;

    logic [15:0]   frame_q;
    logic [2:0]    idx_q;

    logic          push;
    logic          pop;
    logic          strobe;
    logic          idx_inc;
    logic [3:0]    nibble;
    logic [7:0]    byte_sel;

    // Ready depends only on the registered count, so a pop never frees a slot on its own edge.
    assign smp_rdy_o  = (cnt_q != CW'(FIFO_DEPTH));
    assign push       = smp_vld_i & smp_rdy_o;
    assign fifo_cnt_o = cnt_q;

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= smp_dat_i;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // A dropped sample wins over a clear on the same edge.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            ovf_o <= 1'b0;
        end else if (smp_vld_i && !smp_rdy_o) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        strobe  = 1'b0;
        idx_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop     = 1'b1;
                state_d = WR;
            end
            WR: begin
                if (!uart_busy_i) begin
                    strobe  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (uart_busy_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!uart_busy_i) begin
                    if (idx_q == 3'd5) begin
                        state_d = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = WR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            frame_q <= '0;
            idx_q   <= '0;
        end else if (pop) begin
            frame_q <= mem[rd_ptr_q];
            idx_q   <= '0;
        end else if (idx_inc) begin
            idx_q   <= idx_q + 3'd1;
        end
    end

    // Bytes 0..3 are hex digits, most significant nibble first; 4 and 5 are CR and LF.
    always_comb begin
        case (idx_q)
            3'd0:    nibble = frame_q[15:12];
            3'd1:    nibble = frame_q[11:8];
            3'd2:    nibble = frame_q[7:4];
            default: nibble = frame_q[3:0];
        endcase
        if (nibble < 4'd10) begin
            byte_sel = 8'h30 + {4'h0, nibble};
        end else begin
            byte_sel = 8'h37 + {4'h0, nibble};
        end
        if (idx_q == 3'd4) begin
            byte_sel = 8'h0D;
        end else if (idx_q == 3'd5) begin
            byte_sel = 8'h0A;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            uart_wr_o  <= 1'b0;
            uart_dat_o <= 8'h00;
        end else begin
            uart_wr_o <= strobe;
            if (strobe) begin
                uart_dat_o <= byte_sel;
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_framer.sv
// Directed bench for uart_hex_framer: a simple UART model stays busy for 10 cycles
// after each strobe, and every strobed byte is logged and compared with hand-written frames.
module tb_uart_hex_framer;

    localparam int FIFO_DEPTH = 4;

    logic        sys_clk_i   = 1'b0;
    logic        sys_rst_n_i = 1'b1;
    logic [15:0] smp_dat_i   = 16'h0000;
    logic        smp_vld_i   = 1'b0;
    logic        smp_rdy_o;
    logic        uart_busy_i;
    logic        uart_wr_o;
    logic [7:0]  uart_dat_o;
    logic [2:0]  fifo_cnt_o;
    logic        ovf_o;
    logic        ovf_clr_i   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    logic force_busy    = 1'b0;
    logic model_busy    = 1'b0;
    int   busy_left     = 0;
    int   busy_strobes  = 0;
    int   double_strobes = 0;
    logic prev_wr       = 1'b0;
    int   peak_cnt      = 0;

    assign uart_busy_i = force_busy | model_busy;

    uart_hex_framer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .smp_dat_i   (smp_dat_i),
        .smp_vld_i   (smp_vld_i),
        .smp_rdy_o   (smp_rdy_o),
        .uart_busy_i (uart_busy_i),
        .uart_wr_o   (uart_wr_o),
        .uart_dat_o  (uart_dat_o),
        .fifo_cnt_o  (fifo_cnt_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    // UART model and byte logger, evaluated mid-cycle away from the active edge.
    always @(negedge sys_clk_i) begin
        if (uart_wr_o) begin
            rx_q.push_back(uart_dat_o);
            if (uart_busy_i) busy_strobes++;
            if (prev_wr) double_strobes++;
        end
        prev_wr = uart_wr_o;
        if (int'(fifo_cnt_o) > peak_cnt) peak_cnt = int'(fifo_cnt_o);
        if (model_busy) begin
            busy_left--;
            if (busy_left == 0) model_busy = 1'b0;
        end
        if (uart_wr_o) begin
            model_busy = 1'b1;
            busy_left  = 10;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic add_frames(input string hex);
        for (int i = 0; i < hex.len(); i++) begin
            exp_q.push_back(8'(hex[i]));
            if (i % 4 == 3) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit timed_out);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge sys_clk_i);
            c++;
        end
        timed_out = (rx_q.size() < n);
        repeat (40) @(negedge sys_clk_i);
    endtask

    task automatic test_reset;
        #3 sys_rst_n_i = 1'b0;
        repeat (3) @(negedge sys_clk_i);
        n_checks++; if (uart_wr_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr: got %b, expected 0", uart_wr_o); end
        n_checks++; if (uart_dat_o !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_dat: got %h, expected 00", uart_dat_o); end
        n_checks++; if (fifo_cnt_o !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d, expected 0", fifo_cnt_o); end
        n_checks++; if (smp_rdy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rdy: got %b, expected 1", smp_rdy_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b, expected 0", ovf_o); end
        sys_rst_n_i = 1'b1;
        repeat (2) @(negedge sys_clk_i);
    endtask

    task automatic test_single_frame;
        int lat;
        bit to;
        logic [7:0] exp_b [6];
        exp_b = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
        rx_q.delete();
        smp_dat_i = 16'h1A2F;
        smp_vld_i = 1'b1;
        @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        smp_vld_i = 1'b0;
        lat = 0;
        while (!uart_wr_o && lat < 50) begin
            @(negedge sys_clk_i);
            lat++;
        end
        n_checks++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL single_latency: got %0d cycles, expected 3", lat); end
        wait_bytes(6, 500, to);
        n_checks++; if (to) begin n_fail++; $display("[TB] FAIL single_timeout: got %0d bytes, expected 6", rx_q.size()); end
        n_checks++; if (rx_q.size() !== 6) begin n_fail++; $display("[TB] FAIL single_count: got %0d, expected 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_b[i]) begin n_fail++; $display("[TB] FAIL single_byte%0d: got %h, expected %h", i, rx_q[i], exp_b[i]); end
        end
    endtask

    task automatic test_back_to_back;
        bit to;
        rx_q.delete();
        exp_q.delete();
        add_frames("0000FFFF9A5C");
        peak_cnt = 0;
        @(negedge sys_clk_i);
        smp_vld_i = 1'b1; smp_dat_i = 16'h0000;
        @(negedge sys_clk_i);
        smp_dat_i = 16'hFFFF;
        @(negedge sys_clk_i);
        smp_dat_i = 16'h9A5C;
        @(negedge sys_clk_i);
        smp_vld_i = 1'b0;
        wait_bytes(18, 1500, to);
        n_checks++; if (to) begin n_fail++; $display("[TB] FAIL b2b_timeout: got %0d bytes, expected 18", rx_q.size()); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d, expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL b2b_byte%0d: got %h, expected %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (peak_cnt < 2 || peak_cnt > 3) begin n_fail++; $display("[TB] FAIL b2b_peak: got %0d, expected 2..3", peak_cnt); end
        n_checks++; if (busy_strobes !== 0) begin n_fail++; $display("[TB] FAIL strobe_while_busy: got %0d, expected 0", busy_strobes); end
        n_checks++; if (double_strobes !== 0) begin n_fail++; $display("[TB] FAIL double_strobe: got %0d, expected 0", double_strobes); end
    endtask

    task automatic test_overflow;
        logic [15:0] smp [4];
        smp = '{16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F};
        rx_q.delete();
        @(negedge sys_clk_i);
        force_busy = 1'b1;
        smp_dat_i = 16'h1234; smp_vld_i = 1'b1;
        @(negedge sys_clk_i);
        smp_vld_i = 1'b0;
        repeat (5) @(negedge sys_clk_i);
        n_checks++; if (fifo_cnt_o !== 3'd0) begin n_fail++; $display("[TB] FAIL ovf_preload_cnt: got %0d, expected 0", fifo_cnt_o); end
        for (int k = 0; k < 4; k++) begin
            smp_dat_i = smp[k]; smp_vld_i = 1'b1;
            @(negedge sys_clk_i);
            n_checks++; if (fifo_cnt_o !== 3'(k + 1)) begin n_fail++; $display("[TB] FAIL ovf_cnt%0d: got %0d, expected %0d", k, fifo_cnt_o, k + 1); end
            n_checks++; if (smp_rdy_o !== (k < 3)) begin n_fail++; $display("[TB] FAIL ovf_rdy%0d: got %b, expected %b", k, smp_rdy_o, (k < 3)); end
        end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_early: got %b, expected 0", ovf_o); end
        smp_dat_i = 16'hC0DE;
        @(negedge sys_clk_i);
        smp_vld_i = 1'b0;
        n_checks++; if (ovf_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %b, expected 1", ovf_o); end
        n_checks++; if (fifo_cnt_o !== 3'd4) begin n_fail++; $display("[TB] FAIL ovf_full_cnt: got %0d, expected 4", fifo_cnt_o); end
        repeat (3) @(negedge sys_clk_i);
        n_checks++; if (ovf_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b, expected 1", ovf_o); end
        smp_vld_i = 1'b1; ovf_clr_i = 1'b1;
        @(negedge sys_clk_i);
        smp_vld_i = 1'b0; ovf_clr_i = 1'b0;
        n_checks++; if (ovf_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set_priority: got %b, expected 1", ovf_o); end
        ovf_clr_i = 1'b1;
        @(negedge sys_clk_i);
        ovf_clr_i = 1'b0;
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear: got %b, expected 0", ovf_o); end
        n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("[TB] FAIL ovf_no_strobe: got %0d bytes, expected 0", rx_q.size()); end
    endtask

    task automatic test_full_pop_push;
        int n;
        bit to;
        exp_q.delete();
        add_frames("123456789ABCDEF00F0F7777");
        smp_dat_i = 16'h7777; smp_vld_i = 1'b1;
        force_busy = 1'b0;
        n = 0;
        do begin
            @(negedge sys_clk_i);
            n++;
        end while (fifo_cnt_o == 3'd4 && n < 300);
        n_checks++; if (n >= 300) begin n_fail++; $display("[TB] FAIL fpp_timeout: got %0d cycles, expected under 300", n); end
        n_checks++; if (fifo_cnt_o !== 3'd3) begin n_fail++; $display("[TB] FAIL fpp_refused: got cnt %0d, expected 3", fifo_cnt_o); end
        n_checks++; if (ovf_o !== 1'b1) begin n_fail++; $display("[TB] FAIL fpp_ovf: got %b, expected 1", ovf_o); end
        n_checks++; if (smp_rdy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL fpp_rdy: got %b, expected 1", smp_rdy_o); end
        @(negedge sys_clk_i);
        smp_vld_i = 1'b0;
        n_checks++; if (fifo_cnt_o !== 3'd4) begin n_fail++; $display("[TB] FAIL fpp_accept: got cnt %0d, expected 4", fifo_cnt_o); end
        wait_bytes(36, 3000, to);
        n_checks++; if (to) begin n_fail++; $display("[TB] FAIL fpp_drain_timeout: got %0d bytes, expected 36", rx_q.size()); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL fpp_count: got %0d, expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL fpp_byte%0d: got %h, expected %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int k;
        int n;
        bit to;
        rx_q.delete();
        exp_q.delete();
        add_frames("0001");
        n_checks++; if (ovf_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre_ovf: got %b, expected 1", ovf_o); end
        @(negedge sys_clk_i);
        smp_dat_i = 16'hBEEF; smp_vld_i = 1'b1;
        @(negedge sys_clk_i);
        smp_dat_i = 16'h2222;
        @(negedge sys_clk_i);
        smp_vld_i = 1'b0;
        k = 0; n = 0;
        while (k < 3 && n < 500) begin
            @(negedge sys_clk_i);
            n++;
            if (uart_wr_o) k++;
        end
        n_checks++; if (k !== 3) begin n_fail++; $display("[TB] FAIL rst_strobes: got %0d, expected 3", k); end
        #2 sys_rst_n_i = 1'b0;
        #1;
        n_checks++; if (uart_wr_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_async_wr: got %b, expected 0", uart_wr_o); end
        n_checks++; if (uart_dat_o !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_async_dat: got %h, expected 00", uart_dat_o); end
        n_checks++; if (fifo_cnt_o !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_async_cnt: got %0d, expected 0", fifo_cnt_o); end
        n_checks++; if (smp_rdy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_async_rdy: got %b, expected 1", smp_rdy_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_async_ovf: got %b, expected 0", ovf_o); end
        n_checks++; if (rx_q.size() !== 3) begin n_fail++; $display("[TB] FAIL rst_partial_count: got %0d, expected 3", rx_q.size()); end
        else begin
            n_checks++; if (rx_q[0] !== 8'h42) begin n_fail++; $display("[TB] FAIL rst_partial0: got %h, expected 42", rx_q[0]); end
            n_checks++; if (rx_q[2] !== 8'h45) begin n_fail++; $display("[TB] FAIL rst_partial2: got %h, expected 45", rx_q[2]); end
        end
        repeat (2) @(negedge sys_clk_i);
        rx_q.delete();
        sys_rst_n_i = 1'b1;
        smp_dat_i = 16'h0001; smp_vld_i = 1'b1;
        @(negedge sys_clk_i);
        smp_vld_i = 1'b0;
        n_checks++; if (fifo_cnt_o !== 3'd1) begin n_fail++; $display("[TB] FAIL rst_first_push: got cnt %0d, expected 1", fifo_cnt_o); end
        wait_bytes(6, 1000, to);
        n_checks++; if (to) begin n_fail++; $display("[TB] FAIL rst_timeout: got %0d bytes, expected 6", rx_q.size()); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL rst_count: got %0d, expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rst_byte%0d: got %h, expected %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (busy_strobes !== 0) begin n_fail++; $display("[TB] FAIL final_strobe_while_busy: got %0d, expected 0", busy_strobes); end
        n_checks++; if (double_strobes !== 0) begin n_fail++; $display("[TB] FAIL final_double_strobe: got %0d, expected 0", double_strobes); end
    endtask

    initial begin
        $display("[TB] starting uart_hex_framer bench");
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_full_pop_push();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_hex_framer.md
UART_HEX_FRAMER -- requirements
Module: uart_hex_framer

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, sample FIFO entries (power of two, 2..16).
REQ-002 SHALL have port: sys_clk_i  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port: sys_rst_n_i  input  1  system reset; asynchronous and active-low.
REQ-004 SHALL have port: smp_dat_i  input  16  energy sample word to transmit.
REQ-005 SHALL have port: smp_vld_i  input  1  sample valid.
REQ-006 SHALL have port: smp_rdy_o  output  1  sample FIFO not full.
REQ-007 SHALL have port: uart_busy_i  input  1  UART transmitter busy, driven by the downstream UART.
REQ-008 SHALL have port: uart_wr_o  output  1  one-cycle write strobe to the UART.
REQ-009 SHALL have port: uart_dat_o  output  8  byte to transmit, registered.
REQ-010 SHALL have port: fifo_cnt_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port: ovf_o  output  1  sticky overflow flag: a sample was dropped.
REQ-012 SHALL have port: ovf_clr_i  input  1  clears ovf_o.

Function
REQ-013 SHALL push smp_dat_i into the FIFO on a rising edge where smp_vld_i and smp_rdy_o are both 1.
REQ-014 SHALL drive smp_rdy_o = (fifo_cnt_o != FIFO_DEPTH), computed from registered state only.
REQ-015 SHALL refuse a push when full, even if a pop occurs on the same edge; the pop does not free a slot until the next cycle.
REQ-016 SHALL support simultaneous push and pop when not full; fifo_cnt_o is then unchanged.
REQ-017 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-018 SHALL set ovf_o on any edge where smp_vld_i is 1 and smp_rdy_o is 0.
REQ-019 SHALL let set take priority over ovf_clr_i when both occur on the same edge.
REQ-020 SHALL emit each sample as a 6-byte frame: four hex digits, most significant nibble first, then 0x0D, then 0x0A.
REQ-021 SHALL encode hex digits in uppercase ASCII: nibbles 0-9 map to 0x30-0x39; nibbles A-F map to 0x41-0x46.
REQ-022 SHALL use FSM states IDLE, LOAD, WR, ACK and DRAIN.
REQ-023 IDLE SHALL go to LOAD when fifo_cnt_o != 0.
REQ-024 LOAD SHALL pop the FIFO head into a 16-bit frame register, set byte index to 0, and go to WR.
REQ-025 WR SHALL wait while uart_busy_i = 1; when uart_busy_i = 0 it SHALL assert uart_wr_o for exactly one cycle with uart_dat_o = byte[index], then go to ACK.
REQ-026 ACK SHALL wait for uart_busy_i = 1, then go to DRAIN.
REQ-027 DRAIN SHALL wait for uart_busy_i = 0, then go to IDLE if index = 5; otherwise it SHALL increment index and go to WR.
REQ-028 SHALL hold uart_dat_o stable from its strobe cycle until the next strobe.
REQ-029 SHALL never assert uart_wr_o on two consecutive cycles, nor outside state WR.
REQ-030 Latency: with the FSM in IDLE and the FIFO empty, a push on edge N SHALL produce the first uart_wr_o high in the cycle following edge N+3, provided uart_busy_i = 0.
REQ-031 SHALL transmit frames back-to-back in FIFO order, with no bytes dropped or reordered.

Reset
REQ-032 While sys_rst_n_i = 0, the block SHALL asynchronously force: FSM to IDLE, FIFO pointers and count to 0, ovf_o = 0, uart_wr_o = 0, uart_dat_o = 0x00, smp_rdy_o = 1.
REQ-033 Reset asserted mid-frame SHALL abort the frame and discard FIFO contents; after release, no byte of the aborted frame SHALL be resent.
REQ-034 Reset release SHALL be synchronous to sys_clk_i; the first push SHALL be accepted on the first edge after release.

Verification
REQ-035 Test: push 0x1A2F; model the UART as busy for 10 cycles after each strobe -> exactly 6 strobes with bytes 0x31 0x41 0x32 0x46 0x0D 0x0A.
REQ-036 Test: push 0x0000, 0xFFFF, 0x9A5C back-to-back -> 18 strobes in order: "0000\r\n" "FFFF\r\n" "9A5C\r\n"; fifo_cnt_o peaks at 2 or 3; no strobe is issued while busy.
REQ-037 Test: hold uart_busy_i = 1 and push 5 samples with FIFO_DEPTH = 4 -> smp_rdy_o goes low after the 4th push; ovf_o goes to 1 on the 5th push and stays 1; ovf_clr_i clears it.
REQ-038 Test: with the FIFO full, pop and present a new sample on the same edge -> the push is refused and ovf_o = 1; the sample is accepted on the next cycle.
REQ-039 Test: assert sys_rst_n_i low between the 3rd and 4th strobes of 0xBEEF -> outputs reach reset values immediately; after release and a push of 0x0001, only "0001\r\n" is sent.
